// File: rtl/multi_ported_wr_sched_pkg.sv
// Shared types for the multi-ported memory write scheduler: FSM states,
// address-width helper and the default request record.
package multi_ported_wr_sched_pkg;

    localparam int DEF_W = 32;
    localparam int DEF_N = 1024;

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int DEF_AW = addr_width(DEF_N);

    typedef enum logic [1:0] {
        INIT_REQ  = 2'd0,
        INIT_WAIT = 2'd1,
        RUN       = 2'd2
    } state_e;

    typedef struct packed {
        logic [DEF_AW-1:0] addr;
        logic [DEF_W-1:0]  data;
    } req_t;

endpackage

// File: rtl/multi_ported_wr_sched_rr_multi_grant.sv
// Round-robin multi-grant arbiter: scans requesters from rr_ptr_i, grants up to
// NUM_W of them with pairwise-distinct addresses and assigns dense port slots.
module rr_multi_grant #(
    parameter int NUM_REQ = 4,
    parameter int NUM_W   = 3,
    parameter int AW      = 10,
    localparam int PW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int SW     = (NUM_W > 1) ? $clog2(NUM_W) : 1
) (
    input  logic                  en_i,
    input  logic [PW-1:0]         rr_ptr_i,
    input  logic [NUM_REQ-1:0]    valid_i,
    input  logic [NUM_REQ*AW-1:0] addr_i,
    output logic [NUM_REQ-1:0]    grant_o,
    output logic [NUM_REQ*SW-1:0] slot_o,
    output logic [PW-1:0]         next_ptr_o
);

    logic [AW-1:0] taken [NUM_W];
    int            n_granted;
    int            idx;
    logic          clash;

    always_comb begin
        grant_o    = '0;
        slot_o     = '0;
        next_ptr_o = rr_ptr_i;
        n_granted  = 0;
        idx        = 0;
        clash      = 1'b0;
        for (int p = 0; p < NUM_W; p++) begin
            taken[p] = '0;
        end
        if (en_i) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(rr_ptr_i) + k;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                // Inner loop over constant i keeps every select statically indexed.
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (i == idx) begin
                        clash = 1'b0;
                        for (int p = 0; p < NUM_W; p++) begin
                            if (p < n_granted && taken[p] == addr_i[i*AW +: AW]) begin
                                clash = 1'b1;
                            end
                        end
                        if (valid_i[i] && n_granted < NUM_W && !clash) begin
                            grant_o[i]            = 1'b1;
                            slot_o[i*SW +: SW]    = SW'(n_granted);
                            for (int p = 0; p < NUM_W; p++) begin
                                if (p == n_granted) begin
                                    taken[p] = addr_i[i*AW +: AW];
                                end
                            end
                            next_ptr_o = (i == NUM_REQ - 1) ? '0 : PW'(i + 1);
                            n_granted  = n_granted + 1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/multi_ported_wr_sched.sv
// Write-side scheduler for the multi-ported memory: sequences memory init,
// then shares NUM_W write ports among NUM_REQ requesters round-robin.
import multi_ported_wr_sched_pkg::*;

module multi_ported_wr_sched #(
    parameter int NUM_REQ = 4,
    parameter int NUM_W   = 3,
    parameter int W       = 32,
    parameter int N       = 1024,
    localparam int AW     = addr_width(N),
    localparam int PW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int SW     = (NUM_W > 1) ? $clog2(NUM_W) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*W-1:0]  req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic                  init_req,
    output logic [NUM_W-1:0]      wen,
    output logic [NUM_W*AW-1:0]   waddr,
    output logic [NUM_W*W-1:0]    wdata,
    output logic                  init,
    input  logic                  busy_w,
    output logic                  ready_o,
    output logic [31:0]           grant_cnt,
    output logic [1:0]            dbg_state_o,
    output logic [PW-1:0]         dbg_rr_ptr_o
);

    // Handshake: requester i transfers in a cycle where req_valid[i] & req_ready[i];
    // req_ready never depends on req_data and is 0 outside RUN.
    state_e              state_q;
    logic                wait_first_q;
    logic                init_q;
    logic [NUM_W-1:0]    wen_q,   wen_d;
    logic [NUM_W*AW-1:0] waddr_q, waddr_d;
    logic [NUM_W*W-1:0]  wdata_q, wdata_d;
    logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [31:0]         grant_cnt_q, grant_cnt_d;

    logic                arb_en;
    logic [NUM_REQ-1:0]  grant;
    logic [NUM_REQ*SW-1:0] slot;

    // A request to re-init or an unexpected busy_w blocks grants this cycle.
    assign arb_en = (state_q == RUN) && !init_req && !busy_w;

    rr_multi_grant #(
        .NUM_REQ(NUM_REQ),
        .NUM_W  (NUM_W),
        .AW     (AW)
    ) u_arb (
        .en_i      (arb_en),
        .rr_ptr_i  (rr_ptr_q),
        .valid_i   (req_valid),
        .addr_i    (req_addr),
        .grant_o   (grant),
        .slot_o    (slot),
        .next_ptr_o(rr_ptr_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= INIT_REQ;
            wait_first_q <= 1'b0;
            init_q       <= 1'b0;
        end else begin
            case (state_q)
                INIT_REQ: begin
                    init_q       <= 1'b1;
                    wait_first_q <= 1'b1;
                    state_q      <= INIT_WAIT;
                end
                INIT_WAIT: begin
                    init_q <= 1'b0;
                    // busy_w is ignored on the first cycle: the memory has not yet seen init.
                    if (wait_first_q) begin
                        wait_first_q <= 1'b0;
                    end else if (!busy_w) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    init_q <= 1'b0;
                    if (init_req) begin
                        state_q <= INIT_REQ;
                    end
                end
                default: begin
                    init_q  <= 1'b0;
                    state_q <= INIT_REQ;
                end
            endcase
        end
    end

    always_comb begin
        wen_d       = '0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        grant_cnt_d = grant_cnt_q + 32'($countones(grant));
        for (int p = 0; p < NUM_W; p++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i] && int'(slot[i*SW +: SW]) == p) begin
                    wen_d[p]           = 1'b1;
                    waddr_d[p*AW +: AW] = req_addr[i*AW +: AW];
                    wdata_d[p*W +: W]   = req_data[i*W +: W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wen_q       <= '0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            rr_ptr_q    <= '0;
            grant_cnt_q <= '0;
        end else begin
            wen_q       <= wen_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_cnt_q <= grant_cnt_d;
        end
    end

    assign req_ready    = grant;
    assign wen          = wen_q;
    assign waddr        = waddr_q;
    assign wdata        = wdata_q;
    assign init         = init_q;
    assign ready_o      = (state_q == RUN);
    assign grant_cnt    = grant_cnt_q;
    assign dbg_state_o  = state_q;
    assign dbg_rr_ptr_o = rr_ptr_q;

endmodule

// File: tb/tb_multi_ported_wr_sched.sv
// Directed bench for multi_ported_wr_sched with a small memory model on the
// write ports; every expected value below is hand-derived.
module tb_multi_ported_wr_sched;
    import multi_ported_wr_sched_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int NUM_W   = 3;
    localparam int W       = 32;
    localparam int N       = 1024;
    localparam int AW      = 10;
    localparam int PW      = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ*W-1:0]  req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  init_req;
    logic [NUM_W-1:0]      wen;
    logic [NUM_W*AW-1:0]   waddr;
    logic [NUM_W*W-1:0]    wdata;
    logic                  init;
    logic                  busy_w;
    logic                  ready_o;
    logic [31:0]           grant_cnt;
    logic [1:0]            dbg_state;
    logic [PW-1:0]         dbg_rr_ptr;

    int total = 0;
    int bad   = 0;
    int gcnt [NUM_REQ];
    int full_cycles;
    logic [W-1:0] mem [N];

    multi_ported_wr_sched #(
        .NUM_REQ(NUM_REQ), .NUM_W(NUM_W), .W(W), .N(N)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .init_req(init_req),
        .wen(wen), .waddr(waddr), .wdata(wdata), .init(init),
        .busy_w(busy_w), .ready_o(ready_o), .grant_cnt(grant_cnt),
        .dbg_state_o(dbg_state), .dbg_rr_ptr_o(dbg_rr_ptr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int p = 0; p < NUM_W; p++) begin
            if (wen[p]) mem[waddr[p*AW +: AW]] <= wdata[p*W +: W];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input req_t r);
        req_addr[i*AW +: AW] = r.addr;
        req_data[i*W +: W]   = r.data;
    endtask

    function automatic logic [31:0] wa(input int p);
        return 32'(waddr[p*AW +: AW]);
    endfunction

    function automatic logic [31:0] wd(input int p);
        return wdata[p*W +: W];
    endfunction

    initial begin
        rst = 1'b1; init_req = 1'b0; busy_w = 1'b0;
        req_valid = '0; req_addr = '0; req_data = '0;
        tick(); tick();
        chk("rst_state", 32'(dbg_state), 32'(INIT_REQ));
        chk("rst_init", 32'(init), 0);
        chk("rst_wen", 32'(wen), 0);
        chk("rst_waddr1", wa(1), 0);
        chk("rst_wdata2", wd(2), 0);
        chk("rst_ready_o", 32'(ready_o), 0);
        chk("rst_grant_cnt", grant_cnt, 0);
        chk("rst_rr_ptr", 32'(dbg_rr_ptr), 0);

        // Requests held pending through init; none may be granted before RUN.
        for (int i = 0; i < NUM_REQ; i++) begin
            set_req(i, '{addr: 10'(16 * (i + 1)), data: 32'hD000_0000 + 32'(i)});
        end
        req_valid = 4'b1111;
        rst = 1'b0;
        tick();
        chk("init_pulse", 32'(init), 1);
        chk("init_state_wait", 32'(dbg_state), 32'(INIT_WAIT));
        chk("init_req_ready", 32'(req_ready), 0);
        busy_w = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("init_wait_init_low", 32'(init), 0);
            chk("init_wait_ready_o", 32'(ready_o), 0);
            chk("init_wait_req_ready", 32'(req_ready), 0);
        end
        busy_w = 1'b0;
        tick();
        chk("run_ready_o", 32'(ready_o), 1);
        chk("run_state", 32'(dbg_state), 32'(RUN));
        chk("all4_req_ready", 32'(req_ready), 32'b0111);
        tick();
        chk("all4_wen", 32'(wen), 32'b111);
        chk("all4_waddr0", wa(0), 32'h010);
        chk("all4_waddr1", wa(1), 32'h020);
        chk("all4_waddr2", wa(2), 32'h030);
        chk("all4_wdata2", wd(2), 32'hD000_0002);
        chk("all4_rr_ptr", 32'(dbg_rr_ptr), 3);
        chk("all4_cnt", grant_cnt, 3);
        req_valid = 4'b1000;
        #1;
        chk("req3_ready", 32'(req_ready), 32'b1000);
        tick();
        chk("req3_wen", 32'(wen), 32'b001);
        chk("req3_waddr0", wa(0), 32'h040);
        chk("req3_wdata0", wd(0), 32'hD000_0003);
        chk("req3_waddr1_hold", wa(1), 32'h020);
        chk("req3_rr_ptr", 32'(dbg_rr_ptr), 0);
        chk("req3_cnt", grant_cnt, 4);
        req_valid = '0;

        // Same-address clash: requester 1 must wait one cycle.
        set_req(0, '{addr: 10'h155, data: 32'hAAAA_0001});
        set_req(1, '{addr: 10'h155, data: 32'hBBBB_0002});
        req_valid = 4'b0011;
        #1;
        chk("clash_ready", 32'(req_ready), 32'b0001);
        tick();
        chk("clash_wen_a", 32'(wen), 32'b001);
        chk("clash_wdata_a", wd(0), 32'hAAAA_0001);
        chk("clash_rr_ptr_a", 32'(dbg_rr_ptr), 1);
        req_valid = 4'b0010;
        #1;
        chk("clash_ready_b", 32'(req_ready), 32'b0010);
        tick();
        chk("clash_wen_b", 32'(wen), 32'b001);
        chk("clash_waddr_b", wa(0), 32'h155);
        chk("clash_wdata_b", wd(0), 32'hBBBB_0002);
        chk("clash_cnt", grant_cnt, 6);
        req_valid = '0;
        tick();
        chk("idle_wen", 32'(wen), 0);
        chk("clash_mem_read", mem[10'h155], 32'hBBBB_0002);

        // init_req in RUN with two pending requesters.
        set_req(0, '{addr: 10'h100, data: 32'h1111_0000});
        set_req(1, '{addr: 10'h101, data: 32'h2222_0000});
        req_valid = 4'b0011;
        init_req = 1'b1;
        #1;
        chk("reinit_no_grant", 32'(req_ready), 0);
        tick();
        init_req = 1'b0;
        #1;
        chk("reinit_state", 32'(dbg_state), 32'(INIT_REQ));
        chk("reinit_wen", 32'(wen), 0);
        chk("reinit_ready_o", 32'(ready_o), 0);
        chk("reinit_cnt", grant_cnt, 6);
        chk("reinit_req_ready", 32'(req_ready), 0);
        tick();
        chk("reinit_pulse", 32'(init), 1);
        busy_w = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("reinit_wait_ready", 32'(req_ready), 0);
        end
        busy_w = 1'b0;
        tick();
        chk("reinit_run_ready", 32'(req_ready), 32'b0011);
        tick();
        chk("reinit_wen", 32'(wen), 32'b011);
        chk("reinit_waddr0", wa(0), 32'h100);
        chk("reinit_waddr1", wa(1), 32'h101);
        chk("reinit_wdata1", wd(1), 32'h2222_0000);
        chk("reinit_waddr2_hold", wa(2), 32'h030);
        chk("reinit_rr_ptr", 32'(dbg_rr_ptr), 2);
        chk("reinit_cnt2", grant_cnt, 8);
        req_valid = '0;

        // Fairness soak: all four valid with distinct addresses.
        for (int i = 0; i < NUM_REQ; i++) begin
            set_req(i, '{addr: 10'h300 + 10'(i), data: 32'h5A00_0000 + 32'(i)});
            gcnt[i] = 0;
        end
        full_cycles = 0;
        req_valid = 4'b1111;
        #1;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i]) gcnt[i]++;
            end
            if ($countones(req_ready) == NUM_W) full_cycles++;
            tick();
        end
        req_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            chk($sformatf("soak_fair_%0d", i), 32'(gcnt[i] >= 299 && gcnt[i] <= 301), 1);
        end
        chk("soak_full_cycles", 32'(full_cycles), 400);
        chk("soak_cnt", grant_cnt, 1208);
        chk("soak_rr_ptr", 32'(dbg_rr_ptr), 2);

        // Clash skip with a later requester still granted; rr_ptr=2.
        set_req(0, '{addr: 10'h200, data: 32'h0A0A_0A0A});
        set_req(1, '{addr: 10'h201, data: 32'h0B0B_0B0B});
        set_req(2, '{addr: 10'h200, data: 32'h0C0C_0C0C});
        req_valid = 4'b0111;
        #1;
        chk("skip_ready", 32'(req_ready), 32'b0110);
        tick();
        chk("skip_wen", 32'(wen), 32'b011);
        chk("skip_waddr0", wa(0), 32'h200);
        chk("skip_wdata0", wd(0), 32'h0C0C_0C0C);
        chk("skip_waddr1", wa(1), 32'h201);
        chk("skip_rr_ptr", 32'(dbg_rr_ptr), 2);
        chk("skip_cnt", grant_cnt, 1210);
        req_valid = 4'b0001;
        busy_w = 1'b1;
        #1;
        chk("busy_run_ready", 32'(req_ready), 0);
        tick();
        chk("busy_run_wen", 32'(wen), 0);
        chk("busy_run_state", 32'(dbg_state), 32'(RUN));
        busy_w = 1'b0;
        #1;
        chk("retry_ready", 32'(req_ready), 32'b0001);
        tick();
        chk("retry_wen", 32'(wen), 32'b001);
        chk("retry_wdata0", wd(0), 32'h0A0A_0A0A);
        chk("retry_rr_ptr", 32'(dbg_rr_ptr), 1);
        chk("retry_cnt", grant_cnt, 1211);
        req_valid = '0;

        // Reset while in INIT_WAIT.
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        tick();
        chk("pre_rst_state", 32'(dbg_state), 32'(INIT_WAIT));
        rst = 1'b1;
        tick();
        chk("midrst_state", 32'(dbg_state), 32'(INIT_REQ));
        chk("midrst_init", 32'(init), 0);
        chk("midrst_wen", 32'(wen), 0);
        chk("midrst_waddr0", wa(0), 0);
        chk("midrst_wdata0", wd(0), 0);
        chk("midrst_cnt", grant_cnt, 0);
        chk("midrst_rr_ptr", 32'(dbg_rr_ptr), 0);
        chk("midrst_ready_o", 32'(ready_o), 0);
        rst = 1'b0;
        tick();
        chk("midrst_repulse", 32'(init), 1);
        chk("midrst_wait", 32'(dbg_state), 32'(INIT_WAIT));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
